// File: rtl/draw_pkg.sv
// Shared types and widths for the frame draw path.
// Optional overrun counter in the top: OVERRUN_CNT_EN.
package draw_pkg;

  localparam int X_W             = 8;
  localparam int Y_W             = 7;
  localparam int COLOR_DEPTH_DEF = 9;
  localparam int OFFSET_W_DEF    = 7;
  localparam int MAX_OFFSET_DEF  = 80;
  localparam int BUSY_TIMEOUT    = 4;
  localparam int TMO_W           = 2;

  typedef enum logic [2:0] {
    IDLE,
    COMMIT,
    BG_GO,
    BG_BUSY,
    BG_RUN,
    SPR_GO,
    SPR_BUSY,
    SPR_RUN
  } state_t;

endpackage

// File: rtl/offset_scroller.sv
// Tile x_offset register with saturating +/-1 step.
// Only moves on a commit strobe, so it is frame-stable.
module offset_scroller
  import draw_pkg::*;
#(
  parameter int OFFSET_W   = OFFSET_W_DEF,
  parameter int MAX_OFFSET = MAX_OFFSET_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                commit,
  input  logic                scroll_right,
  input  logic                scroll_left,
  output logic [OFFSET_W-1:0] x_offset
);

  localparam logic [OFFSET_W-1:0] MAX_V =
    OFFSET_W'(MAX_OFFSET);

  logic [OFFSET_W-1:0] x_offset_q;
  logic [OFFSET_W-1:0] x_offset_d;

  // next offset: step once per commit, clamp at both ends
  always_comb begin
    x_offset_d = x_offset_q;
    if (commit) begin
      unique case (1'b1)
        scroll_right & ~scroll_left: begin
          if (x_offset_q < MAX_V)
            x_offset_d = x_offset_q + 1'b1;
        end
        scroll_left & ~scroll_right: begin
          if (x_offset_q != '0)
            x_offset_d = x_offset_q - 1'b1;
        end
        default: x_offset_d = x_offset_q;
      endcase
    end
  end

  // offset register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) x_offset_q <= '0;
    else         x_offset_q <= x_offset_d;
  end

  assign x_offset = x_offset_q;

endmodule

// File: rtl/frame_draw_scheduler.sv
// Per-frame sequencer: commit scroll, bg draw, sprite draw.
// Owns the VGA write port. Option: OVERRUN_CNT_EN.
module frame_draw_scheduler
  import draw_pkg::*;
#(
  parameter int COLOR_DEPTH = COLOR_DEPTH_DEF,
  parameter int OFFSET_W    = OFFSET_W_DEF,
  parameter int MAX_OFFSET  = MAX_OFFSET_DEF
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic                   scroll_right,
  input  logic                   scroll_left,
  output logic [OFFSET_W-1:0]    x_offset,
  output logic                   bg_enable,
  input  logic                   bg_done,
  input  logic [X_W-1:0]         bg_x,
  input  logic [Y_W-1:0]         bg_y,
  input  logic [COLOR_DEPTH-1:0] bg_color,
  input  logic                   bg_plot,
  output logic                   spr_enable,
  input  logic                   spr_done,
  input  logic [X_W-1:0]         spr_x,
  input  logic [Y_W-1:0]         spr_y,
  input  logic [COLOR_DEPTH-1:0] spr_color,
  input  logic                   spr_plot,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [COLOR_DEPTH-1:0] vga_color,
  output logic                   vga_plot,
  output logic                   busy,
  output logic [7:0]             overrun_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(BUSY_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             bg_enable_q, bg_enable_d;
  logic             spr_enable_q, spr_enable_d;
  logic             commit;

  assign busy       = (state_q != IDLE);
  assign bg_enable  = bg_enable_q;
  assign spr_enable = spr_enable_q;

  offset_scroller #(
    .OFFSET_W   (OFFSET_W),
    .MAX_OFFSET (MAX_OFFSET)
  ) u_scroll (
    .clock        (clock),
    .resetn       (resetn),
    .commit       (commit),
    .scroll_right (scroll_right),
    .scroll_left  (scroll_left),
    .x_offset     (x_offset)
  );

  // next state, pending merge, busy-wait timeout, strobes
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    tmo_d     = tmo_q;
    commit    = 1'b0;
    if (frame_tick && busy) pending_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (frame_tick || pending_q) begin
          state_d   = COMMIT;
          pending_d = 1'b0;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = BG_GO;
      end
      BG_GO: begin
        tmo_d   = '0;
        state_d = BG_BUSY;
      end
      BG_BUSY: begin
        if (!bg_done)              state_d = BG_RUN;
        else if (tmo_q == TMO_LAST) state_d = SPR_GO;
        else                       tmo_d   = tmo_q + 1'b1;
      end
      BG_RUN: begin
        if (bg_done) state_d = SPR_GO;
      end
      SPR_GO: begin
        tmo_d   = '0;
        state_d = SPR_BUSY;
      end
      SPR_BUSY: begin
        if (!spr_done)             state_d = SPR_RUN;
        else if (tmo_q == TMO_LAST) state_d = IDLE;
        else                       tmo_d   = tmo_q + 1'b1;
      end
      SPR_RUN: begin
        if (spr_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    bg_enable_d  = (state_d == BG_GO);
    spr_enable_d = (state_d == SPR_GO);
  end

  // FSM and strobe registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      tmo_q        <= '0;
      bg_enable_q  <= 1'b0;
      spr_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      tmo_q        <= tmo_d;
      bg_enable_q  <= bg_enable_d;
      spr_enable_q <= spr_enable_d;
    end
  end

  // VGA port mux: only the active drawer reaches the adapter
  always_comb begin
    vga_x     = '0;
    vga_y     = '0;
    vga_color = '0;
    vga_plot  = 1'b0;
    unique case (state_q)
      BG_BUSY, BG_RUN: begin
        vga_x     = bg_x;
        vga_y     = bg_y;
        vga_color = bg_color;
        vga_plot  = bg_plot;
      end
      SPR_BUSY, SPR_RUN: begin
        vga_x     = spr_x;
        vga_y     = spr_y;
        vga_color = spr_color;
        vga_plot  = spr_plot;
      end
      default: vga_plot = 1'b0;
    endcase
  end

`ifdef OVERRUN_CNT_EN
  logic [7:0] overrun_q, overrun_d;

  // saturating count of ticks that landed mid-frame
  always_comb begin
    overrun_d = overrun_q;
    if (frame_tick && busy && overrun_q != 8'hFF)
      overrun_d = overrun_q + 8'd1;
  end

  // overrun counter register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) overrun_q <= 8'd0;
    else         overrun_q <= overrun_d;
  end

  assign overrun_cnt = overrun_q;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Directed bench for frame_draw_scheduler.
// Behavioural drawers; overrun expectation follows OVERRUN_CNT_EN.
module tb_frame_draw_scheduler;
  import draw_pkg::*;

  logic       clock = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic       scroll_right;
  logic       scroll_left;
  logic [6:0] x_offset;
  logic       bg_enable, bg_done;
  logic [7:0] bg_x;
  logic [6:0] bg_y;
  logic [8:0] bg_color;
  logic       bg_plot;
  logic       spr_enable, spr_done;
  logic [7:0] spr_x;
  logic [6:0] spr_y;
  logic [8:0] spr_color;
  logic       spr_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [8:0] vga_color;
  logic       vga_plot;
  logic       busy;
  logic [7:0] overrun_cnt;

  int n_vec = 0;
  int n_bad = 0;

  frame_draw_scheduler dut (
    .clock        (clock),
    .resetn       (resetn),
    .frame_tick   (frame_tick),
    .scroll_right (scroll_right),
    .scroll_left  (scroll_left),
    .x_offset     (x_offset),
    .bg_enable    (bg_enable),
    .bg_done      (bg_done),
    .bg_x         (bg_x),
    .bg_y         (bg_y),
    .bg_color     (bg_color),
    .bg_plot      (bg_plot),
    .spr_enable   (spr_enable),
    .spr_done     (spr_done),
    .spr_x        (spr_x),
    .spr_y        (spr_y),
    .spr_color    (spr_color),
    .spr_plot     (spr_plot),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_color    (vga_color),
    .vga_plot     (vga_plot),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  assign bg_x      = cyc[7:0];
  assign bg_y      = 7'h15;
  assign bg_color  = 9'h0AA;
  assign bg_plot   = cyc[0];
  assign spr_x     = ~cyc[7:0];
  assign spr_y     = 7'h6A;
  assign spr_color = 9'h155;
  assign spr_plot  = cyc[1];

  int bg_len = 300, spr_len = 300;
  bit bg_dead = 1'b0, spr_dead = 1'b0;
  int bg_cnt, spr_cnt;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bg_done <= 1'b1;
      bg_cnt  <= 0;
    end else if (bg_enable && !bg_dead) begin
      bg_cnt <= 1;
    end else if (bg_cnt != 0) begin
      bg_cnt <= bg_cnt + 1;
      if (bg_cnt == 1) bg_done <= 1'b0;
      if (bg_cnt == bg_len) begin
        bg_done <= 1'b1;
        bg_cnt  <= 0;
      end
    end
  end

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      spr_done <= 1'b1;
      spr_cnt  <= 0;
    end else if (spr_enable && !spr_dead) begin
      spr_cnt <= 1;
    end else if (spr_cnt != 0) begin
      spr_cnt <= spr_cnt + 1;
      if (spr_cnt == 1) spr_done <= 1'b0;
      if (spr_cnt == spr_len) begin
        spr_done <= 1'b1;
        spr_cnt  <= 0;
      end
    end
  end

  int bg_pulses = 0, spr_pulses = 0;
  int bg_last = 0, spr_last = 0;
  int mux_bad = 0, bg_seen = 0, spr_seen = 0;

  always @(negedge clock) begin
    if (bg_enable) begin
      bg_pulses <= bg_pulses + 1;
      bg_last   <= cyc;
    end
    if (spr_enable) begin
      spr_pulses <= spr_pulses + 1;
      spr_last   <= cyc;
    end
    if (!busy || bg_enable || spr_enable) begin
      if (vga_plot !== 1'b0) mux_bad <= mux_bad + 1;
    end else if (!bg_done) begin
      bg_seen <= bg_seen + 1;
      if ({vga_x, vga_y, vga_color, vga_plot} !==
          {bg_x, bg_y, bg_color, bg_plot})
        mux_bad <= mux_bad + 1;
    end else if (!spr_done) begin
      spr_seen <= spr_seen + 1;
      if ({vga_x, vga_y, vga_color, vga_plot} !==
          {spr_x, spr_y, spr_color, spr_plot})
        mux_bad <= mux_bad + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag,
                           input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic tick();
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  task automatic frame(input string tag);
    tick();
    wait_idle(tag, 3000);
  endtask

  task automatic wait_low(input string tag,
                          input bit spr);
    int n = 0;
    while ((spr ? spr_done : bg_done) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_low"},
        32'(spr ? spr_done : bg_done), 32'd0);
  endtask

  int b0, s0, n, ov_exp;

  initial begin
    resetn       = 1'b0;
    frame_tick   = 1'b0;
    scroll_right = 1'b0;
    scroll_left  = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_xoff", 32'(x_offset), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bgen", 32'(bg_enable), 32'd0);
    chk("rst_spen", 32'(spr_enable), 32'd0);
    chk("rst_plot", 32'(vga_plot), 32'd0);
    chk("rst_ovr", 32'(overrun_cnt), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    // one long frame: ordered single strobes, mux
    b0 = bg_pulses;
    s0 = spr_pulses;
    frame("f1");
    chk("f1_bg", 32'(bg_pulses - b0), 32'd1);
    chk("f1_spr", 32'(spr_pulses - s0), 32'd1);
    chk("f1_order", 32'(bg_last < spr_last), 32'd1);
    chk("f1_xoff", 32'(x_offset), 32'd0);
    chk("mux_f1", 32'(mux_bad), 32'd0);
    chk("mux_bgcov", 32'(bg_seen > 250), 32'd1);
    chk("mux_sprcov", 32'(spr_seen > 250), 32'd1);

    // scroll right to saturation, then left, then both
    bg_len  = 6;
    spr_len = 6;
    scroll_right = 1'b1;
    for (int k = 1; k <= 85; k++) begin
      frame("sr");
      chk($sformatf("sr%0d", k), 32'(x_offset),
          32'(k < 80 ? k : 80));
    end
    scroll_right = 1'b0;
    scroll_left  = 1'b1;
    frame("sl");
    chk("sl_79", 32'(x_offset), 32'd79);
    scroll_right = 1'b1;
    frame("both");
    chk("both_79", 32'(x_offset), 32'd79);
    scroll_right = 1'b0;
    frame("none");
    chk("sl_78", 32'(x_offset), 32'd78);
    scroll_left = 1'b0;
    frame("none2");
    chk("none_78", 32'(x_offset), 32'd78);

    // sprite drawer never drops done: timeout to IDLE
    spr_dead = 1'b1;
    tick();
    n = 0;
    while (!spr_enable && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("tmo_spren", 32'(spr_enable), 32'd1);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("tmo_len", 32'(n), 32'd5);
    spr_dead = 1'b0;
    s0 = spr_pulses;
    frame("after_tmo");
    chk("after_tmo", 32'(spr_pulses - s0), 32'd1);

    // background drawer dead: still goes on to sprites
    bg_dead = 1'b1;
    b0 = bg_pulses;
    s0 = spr_pulses;
    frame("bgtmo");
    chk("bgtmo_bg", 32'(bg_pulses - b0), 32'd1);
    chk("bgtmo_spr", 32'(spr_pulses - s0), 32'd1);
    bg_dead = 1'b0;

    // three ticks mid-frame merge into one extra frame
    bg_len = 40;
    spr_len = 10;
    b0 = bg_pulses;
    tick();
    wait_low("ovr", 1'b0);
    repeat (3) tick();
    wait_idle("ovr1", 3000);
    @(negedge clock);
    chk("ovr_restart", 32'(busy), 32'd1);
    wait_idle("ovr2", 3000);
    repeat (10) @(negedge clock);
    chk("ovr_quiet", 32'(busy), 32'd0);
    chk("ovr_frames", 32'(bg_pulses - b0), 32'd2);
`ifdef OVERRUN_CNT_EN
    ov_exp = 3;
`else
    ov_exp = 0;
`endif
    chk("ovr_cnt", 32'(overrun_cnt), 32'(ov_exp));

    // walk offset to 40, then reset in the middle of sprites
    bg_len = 6;
    spr_len = 6;
    scroll_left = 1'b1;
    repeat (38) frame("to40");
    chk("xoff_40", 32'(x_offset), 32'd40);
    scroll_left = 1'b0;
    spr_len = 300;
    tick();
    wait_low("mid", 1'b1);
    scroll_right = 1'b1;
    repeat (5) @(negedge clock);
    chk("mid_stable", 32'(x_offset), 32'd40);
    resetn = 1'b0;
    #2;
    chk("ar_xoff", 32'(x_offset), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_plot", 32'(vga_plot), 32'd0);
    chk("ar_spen", 32'(spr_enable), 32'd0);
    chk("ar_ovr", 32'(overrun_cnt), 32'd0);
    scroll_right = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    b0 = bg_pulses;
    s0 = spr_pulses;
    repeat (20) @(negedge clock);
    chk("ar_nobg", 32'(bg_pulses - b0), 32'd0);
    chk("ar_nospr", 32'(spr_pulses - s0), 32'd0);
    chk("ar_idle", 32'(busy), 32'd0);
    spr_len = 6;
    scroll_left = 1'b1;
    frame("ar_next");
    chk("ar_next_bg", 32'(bg_pulses - b0), 32'd1);
    chk("ar_next_spr", 32'(spr_pulses - s0), 32'd1);
    chk("sl_floor", 32'(x_offset), 32'd0);
    scroll_left = 1'b0;

    chk("mux_all", 32'(mux_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
